// File: rtl/gate_sweep_checker_if.sv
// Bundle between the gate sweep checker and the gate block / test environment.
//
// Handshake: start is a request that the checker honours only on a cycle
// where busy is low; once accepted, busy stays high until the cycle after
// the single-cycle done pulse, and any start seen while busy is dropped.
// pass/fail_mask/err_count are valid from done until the next accepted start.
interface gate_sweep_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             drv_a;
    logic             drv_b;
    logic [5:0]       gate_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [5:0]       fail_mask;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       vec_idx;
    logic [1:0]       dbg_state;

    // Environment side: issues start and returns the gate results.
    modport master (
        output start, gate_out,
        input  drv_a, drv_b, busy, done, pass, fail_mask, err_count, vec_idx, dbg_state
    );

    // Checker side.
    modport slave (
        input  start, gate_out,
        output drv_a, drv_b, busy, done, pass, fail_mask, err_count, vec_idx, dbg_state
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// Sweeps the two gate inputs through 00,01,10,11, waits SETTLE_CYCLES per
// vector, compares the six gate outputs with their truth table and reports a
// sticky per-gate fail mask, a saturating mismatch count and a pass flag.
module gate_sweep_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_sweep_checker_if.slave  bus
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       vec_q, vec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [5:0]       mask_q, mask_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic [5:0]       mismatch;
    logic [2:0]       mis_cnt;
    logic [ERR_W:0]   err_sum;

    // Truth table of the gate library, bit order and/or/nand/nor/xor/xnor.
    function automatic logic [5:0] golden(input logic [1:0] v);
        logic a;
        logic b;
        a = v[1];
        b = v[0];
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    endfunction

    // Mismatch bits for the current vector and the saturated running total.
    always_comb begin
        mismatch = bus.gate_out ^ golden(vec_q);
        mis_cnt  = '0;
        for (int i = 0; i < 6; i++) begin
            mis_cnt = mis_cnt + {2'b00, mismatch[i]};
        end
        err_sum = {1'b0, err_q} + (ERR_W + 1)'(mis_cnt);
    end

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        mask_d  = mask_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mask_d  = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    vec_d   = 2'd0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                mask_d = mask_q | mismatch;
                // Never wrap: clip to all-ones when the carry bit is set.
                err_d  = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
                if (vec_q == 2'd3) begin
                    done_d  = 1'b1;
                    pass_d  = ((mask_q | mismatch) == 6'd0);
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
        end
    end

    // The drive lines are the vector index itself, so they hold 11 after a sweep.
    assign bus.drv_a     = vec_q[1];
    assign bus.drv_b     = vec_q[0];
    assign bus.vec_idx   = vec_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = mask_q;
    assign bus.err_count = err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three instances with different settle times
// and counter widths, each fed by a gate model with programmable faults.
module tb_gate_sweep_checker;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- per-instance stimulus and observation ----------------
    logic [2:0]        start_v;
    logic [3:0][5:0]   fault_v [3];
    logic [2:0]        drv_a_v, drv_b_v, busy_v, done_v, pass_v;
    logic [5:0]        mask_v [3];
    logic [7:0]        err_v  [3];
    logic [1:0]        vec_v  [3];

    int checks = 0;
    int errors = 0;

    // Gate truth table from plain arithmetic on the input values.
    function automatic logic [5:0] ref_gate(input int a, input int b);
        logic [5:0] r;
        int s;
        s = a + b;
        r[0] = (a * b == 1);
        r[1] = (s > 0);
        r[2] = (a * b != 1);
        r[3] = (s == 0);
        r[4] = (s == 1);
        r[5] = (s != 1);
        return r;
    endfunction

    function automatic int settle_of(input int k);
        return (k == 1) ? 1 : ((k == 2) ? 4 : 2);
    endfunction

    function automatic int errw_of(input int k);
        return (k == 1) ? 3 : 8;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int S  = (g == 1) ? 1 : ((g == 2) ? 4 : 2);
        localparam int EW = (g == 1) ? 3 : 8;

        gate_sweep_checker_if #(.ERR_W(EW)) bus ();

        gate_sweep_checker #(.SETTLE_CYCLES(S), .ERR_W(EW)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign bus.start    = start_v[g];
        assign bus.gate_out = ref_gate(int'(bus.drv_a), int'(bus.drv_b))
                              ^ fault_v[g][{bus.drv_a, bus.drv_b}];
        assign drv_a_v[g] = bus.drv_a;
        assign drv_b_v[g] = bus.drv_b;
        assign busy_v[g]  = bus.busy;
        assign done_v[g]  = bus.done;
        assign pass_v[g]  = bus.pass;
        assign mask_v[g]  = bus.fail_mask;
        assign err_v[g]   = 8'(bus.err_count);
        assign vec_v[g]   = bus.vec_idx;
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input int k, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL k%0d %s: got %0d expected %0d at %0t", k, name, act, exp, $time);
        end
    endtask

    // Expected sweep result computed straight from the fault pattern.
    task automatic model(input int k, output logic [5:0] m, output int e, output bit p);
        int lim;
        m = '0;
        e = 0;
        for (int v = 0; v < 4; v++) begin
            m = m | fault_v[k][v];
            e = e + $countones(fault_v[k][v]);
        end
        lim = (1 << errw_of(k)) - 1;
        if (e > lim) e = lim;
        p = (m == 6'd0);
    endtask

    task automatic chk_idle_reset(input int k);
        chk(k, "rst drv_a", int'(drv_a_v[k]), 0);
        chk(k, "rst drv_b", int'(drv_b_v[k]), 0);
        chk(k, "rst busy",  int'(busy_v[k]), 0);
        chk(k, "rst done",  int'(done_v[k]), 0);
        chk(k, "rst pass",  int'(pass_v[k]), 0);
        chk(k, "rst mask",  int'(mask_v[k]), 0);
        chk(k, "rst err",   int'(err_v[k]), 0);
        chk(k, "rst vec",   int'(vec_v[k]), 0);
    endtask

    // ---------------- driver ----------------
    // One full sweep on instance k with cycle-exact checks of every output.
    task automatic run_sweep(input int k, input bit glitch, input bit hold,
                             input logic [5:0] e_mask, input int e_err, input bit e_pass);
        int per;
        per = settle_of(k) + 1;
        @(negedge clk);
        start_v[k] = 1'b1;
        @(posedge clk);                      // E0: start accepted
        for (int c = 0; c < 4 * per; c++) begin
            @(negedge clk);
            start_v[k] = hold || (glitch && c == per);
            chk(k, "vec_idx", int'(vec_v[k]), c / per);
            chk(k, "drv", int'({drv_a_v[k], drv_b_v[k]}), c / per);
            chk(k, "busy run", int'(busy_v[k]), 1);
            chk(k, "done early", int'(done_v[k]), 0);
        end
        @(negedge clk);                      // E0 + 4*(S+1): DONE
        chk(k, "done pulse", int'(done_v[k]), 1);
        chk(k, "busy at done", int'(busy_v[k]), 1);
        chk(k, "fail_mask", int'(mask_v[k]), int'(e_mask));
        chk(k, "err_count", int'(err_v[k]), e_err);
        chk(k, "pass", int'(pass_v[k]), int'(e_pass));
        @(negedge clk);
        chk(k, "done clear", int'(done_v[k]), 0);
        chk(k, "busy clear", int'(busy_v[k]), 0);
        chk(k, "drv hold", int'({drv_a_v[k], drv_b_v[k]}), 3);
        chk(k, "mask hold", int'(mask_v[k]), int'(e_mask));
        chk(k, "err hold", int'(err_v[k]), e_err);
        chk(k, "pass hold", int'(pass_v[k]), int'(e_pass));
        if (hold) begin
            @(negedge clk);
            chk(k, "restart busy", int'(busy_v[k]), 1);
            chk(k, "restart err", int'(err_v[k]), 0);
            chk(k, "restart mask", int'(mask_v[k]), 0);
            chk(k, "restart pass", int'(pass_v[k]), 0);
            start_v[k] = 1'b0;
            repeat (4 * per + 1) @(negedge clk);
            chk(k, "second sweep end", int'(busy_v[k]), 0);
            chk(k, "second sweep mask", int'(mask_v[k]), int'(e_mask));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          k;
        logic [23:0] faults;     // {vec3, vec2, vec1, vec0} xor masks
        bit          glitch;
        bit          hold;
        logic [5:0]  exp_mask;
        int          exp_err;
        bit          exp_pass;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [5:0] m_mask;
        int         m_err;
        bit         m_pass;
        int         k;

        tbl[0] = '{0, 24'h000000, 1'b0, 1'b0, 6'h00, 0,  1'b1};
        tbl[1] = '{0, 24'h280000, 1'b0, 1'b0, 6'h0A, 2,  1'b0};
        tbl[2] = '{1, 24'hFFFFFF, 1'b0, 1'b0, 6'h3F, 7,  1'b0};
        tbl[3] = '{2, 24'h000000, 1'b1, 1'b0, 6'h00, 0,  1'b1};
        tbl[4] = '{1, 24'h000000, 1'b0, 1'b0, 6'h00, 0,  1'b1};
        tbl[5] = '{2, 24'h000010, 1'b0, 1'b0, 6'h10, 1,  1'b0};
        tbl[6] = '{0, 24'h000840, 1'b0, 1'b1, 6'h21, 2,  1'b0};
        tbl[7] = '{0, 24'h280000, 1'b1, 1'b0, 6'h0A, 2,  1'b0};
        tbl[8] = '{0, 24'hFFF000, 1'b0, 1'b0, 6'h3F, 12, 1'b0};

        start_v = '0;
        for (int i = 0; i < 3; i++) fault_v[i] = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_idle_reset(i);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table.
        foreach (tbl[i]) begin
            fault_v[tbl[i].k] = tbl[i].faults;
            run_sweep(tbl[i].k, tbl[i].glitch, tbl[i].hold,
                      tbl[i].exp_mask, tbl[i].exp_err, tbl[i].exp_pass);
            repeat (2) @(negedge clk);
        end

        // Randomized fault patterns against the reference model.
        for (int r = 0; r < 12; r++) begin
            k = $urandom_range(0, 2);
            for (int v = 0; v < 4; v++) begin
                fault_v[k][v] = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom);
            end
            model(k, m_mask, m_err, m_pass);
            run_sweep(k, 1'($urandom_range(0, 1)), 1'b0, m_mask, m_err, m_pass);
            @(negedge clk);
        end

        // Reset during SAMPLE of vector 2 on instance 0.
        fault_v[0] = 24'h00003F;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= 2 * 3 + 2; c++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
        end
        chk(0, "pre-reset vec", int'(vec_v[0]), 2);
        chk(0, "pre-reset err", int'(err_v[0]), 6);
        rst_n = 1'b0;
        #1;
        chk_idle_reset(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk(0, "post-reset busy", int'(busy_v[0]), 0);
        chk(0, "post-reset vec", int'(vec_v[0]), 0);
        chk(0, "post-reset err", int'(err_v[0]), 0);
        fault_v[0] = '0;
        run_sweep(0, 1'b0, 1'b0, 6'h00, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
